card_whitelist_checker: RTL

Checks an authenticated 128-bit card ID against a list of authorized IDs held in the AT25010 EEPROM and returns match/no-match plus the matching slot index. It sits directly downstream of the authentication controller: it consumes `card_id` on a successful authentication and gates the door-unlock timer. It reaches the EEPROM through the existing byte-read request path (the key-storage arbiter), using the same req/addr/data/valid handshake as key loading.

---
 rtl/guardian_pkg.sv | 26 ++
 rtl/card_whitelist_checker_if.sv | 27 ++
 rtl/card_whitelist_checker.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/guardian_pkg.sv
// Shared types and EEPROM address-map constants for the access-control datapath.
package guardian_pkg;

  localparam int unsigned WL_ADDR_W     = 7;
  localparam int unsigned WL_DATA_W     = 8;
  localparam int unsigned WL_ID_W       = 128;
  localparam int unsigned WL_SLOT_BYTES = 16;
  localparam int unsigned WL_BYTE_W     = 4;
  localparam int unsigned WL_TMO_W      = 16;

  // AT25010 map: key storage at 0x00-0x3F, whitelist slots from 0x40.
  localparam logic [WL_ADDR_W-1:0] KEY_REGION_BASE = 7'h00;
  localparam logic [WL_ADDR_W-1:0] KEY_REGION_LAST = 7'h3F;
  localparam logic [WL_ADDR_W-1:0] WL_BASE_ADDR    = 7'h40;

  // Erased EEPROM reads back as all-ones; such an ID can never be authorized.
  localparam logic [WL_ID_W-1:0] WL_EMPTY_ID = '1;

  typedef enum logic [1:0] {
    WL_IDLE = 2'd0,
    WL_REQ  = 2'd1,
    WL_WAIT = 2'd2,
    WL_DONE = 2'd3
  } wl_state_t;

endpackage

// File: rtl/card_whitelist_checker_if.sv
// Byte-read request path toward the key-storage arbiter / EEPROM.
interface card_whitelist_checker_if;
  import guardian_pkg::*;

  logic                 mem_req;
  logic [WL_ADDR_W-1:0] mem_addr;
  logic [WL_DATA_W-1:0] mem_rdata;
  logic                 mem_rdata_valid;
  logic                 mem_error;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_rdata_valid,
    input  mem_error
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_rdata_valid,
    output mem_error
  );

endinterface

// File: rtl/card_whitelist_checker.sv
// Compares an authenticated card ID byte-by-byte against EEPROM whitelist slots.
// BASE_ADDR + 16*NUM_SLOTS must not exceed 128 (7-bit address space, no wrap).
module card_whitelist_checker
  import guardian_pkg::*;
#(
  parameter int unsigned          NUM_SLOTS   = 4,
  parameter logic [WL_ADDR_W-1:0] BASE_ADDR   = WL_BASE_ADDR,
  parameter logic [WL_TMO_W-1:0]  MEM_TIMEOUT = 16'd1024,
  localparam int unsigned         SLOT_W      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     check_req,
  input  logic [WL_ID_W-1:0]       card_id,
  output logic                     busy,
  output logic                     check_done,
  output logic                     check_match,
  output logic [SLOT_W-1:0]        match_slot,
  output logic                     check_error,
  card_whitelist_checker_if.master mem
);

  localparam logic [SLOT_W-1:0]    LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [WL_BYTE_W-1:0] LAST_BYTE = WL_BYTE_W'(WL_SLOT_BYTES - 1);

  wl_state_t            state_q, state_d;
  logic [WL_ID_W-1:0]   card_id_q, card_id_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [WL_BYTE_W-1:0] byte_q, byte_d;
  logic [WL_TMO_W-1:0]  tmo_q, tmo_d;
  logic                 busy_q, busy_d;
  logic                 check_done_q, check_done_d;
  logic                 check_match_q, check_match_d;
  logic [SLOT_W-1:0]    match_slot_q, match_slot_d;
  logic                 check_error_q, check_error_d;
  logic                 mem_req_q, mem_req_d;
  logic [WL_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WL_DATA_W-1:0] id_byte_c;

  // State and registered outputs; reset aborts any check in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WL_IDLE;
      card_id_q     <= '0;
      slot_q        <= '0;
      byte_q        <= '0;
      tmo_q         <= '0;
      busy_q        <= 1'b0;
      check_done_q  <= 1'b0;
      check_match_q <= 1'b0;
      match_slot_q  <= '0;
      check_error_q <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      card_id_q     <= card_id_d;
      slot_q        <= slot_d;
      byte_q        <= byte_d;
      tmo_q         <= tmo_d;
      busy_q        <= busy_d;
      check_done_q  <= check_done_d;
      check_match_q <= check_match_d;
      match_slot_q  <= match_slot_d;
      check_error_q <= check_error_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
    end
  end

  // Next-state: walk slots/bytes, early-exit on first mismatch or first full match.
  always_comb begin
    state_d       = state_q;
    card_id_d     = card_id_q;
    slot_d        = slot_q;
    byte_d        = byte_q;
    tmo_d         = tmo_q;
    check_done_d  = 1'b0;
    check_match_d = check_match_q;
    match_slot_d  = match_slot_q;
    check_error_d = check_error_q;
    mem_req_d     = 1'b0;
    mem_addr_d    = mem_addr_q;
    // Byte 0 is the MSB of the ID.
    id_byte_c     = card_id_q[{LAST_BYTE - byte_q, 3'b000} +: WL_DATA_W];

    case (state_q)
      WL_IDLE: begin
        if (check_req && !busy_q) begin
          card_id_d     = card_id;
          check_match_d = 1'b0;
          match_slot_d  = '0;
          check_error_d = 1'b0;
          slot_d        = '0;
          byte_d        = '0;
          state_d       = (card_id == WL_EMPTY_ID) ? WL_DONE : WL_REQ;
        end
      end

      WL_REQ: begin
        mem_req_d  = 1'b1;
        mem_addr_d = BASE_ADDR + WL_ADDR_W'({slot_q, 4'b0000}) + WL_ADDR_W'(byte_q);
        tmo_d      = MEM_TIMEOUT;
        state_d    = WL_WAIT;
      end

      WL_WAIT: begin
        tmo_d = tmo_q - WL_TMO_W'(1);
        if (mem.mem_error) begin
          check_error_d = 1'b1;
          check_match_d = 1'b0;
          state_d       = WL_DONE;
        end else if (mem.mem_rdata_valid) begin
          if (mem.mem_rdata == id_byte_c) begin
            if (byte_q == LAST_BYTE) begin
              check_match_d = 1'b1;
              match_slot_d  = slot_q;
              state_d       = WL_DONE;
            end else begin
              byte_d  = byte_q + WL_BYTE_W'(1);
              state_d = WL_REQ;
            end
          end else begin
            byte_d = '0;
            if (slot_q == LAST_SLOT) begin
              state_d = WL_DONE;
            end else begin
              slot_d  = slot_q + SLOT_W'(1);
              state_d = WL_REQ;
            end
          end
        end else if (tmo_q <= WL_TMO_W'(1)) begin
          check_error_d = 1'b1;
          check_match_d = 1'b0;
          state_d       = WL_DONE;
        end
      end

      WL_DONE: begin
        check_done_d = 1'b1;
        state_d      = WL_IDLE;
      end

      default: state_d = WL_IDLE;
    endcase

    // Busy covers the whole check including the cycle check_done is visible.
    busy_d = (state_d != WL_IDLE) || (state_q == WL_DONE);
  end

  assign busy         = busy_q;
  assign check_done   = check_done_q;
  assign check_match  = check_match_q;
  assign match_slot   = match_slot_q;
  assign check_error  = check_error_q;
  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;

endmodule
